lifo_fifo_buffer: RTL
=====================

Name: lifo_fifo_buffer

Overview:
- Parametrised storage buffer with run-time selectable LIFO (stack) or FIFO (queue) ordering.
- Adds occupancy count, programmable almost-full and almost-empty thresholds, and sticky-free overflow/underflow error pulses.
- Non-power-of-two depths are supported.
- Sits between a producer and a consumer, for example as a command/return stack or a rate-matching queue. It is the generalised successor of the team's single-mode stack buffer.

Parameters:
- DEPTH, 8: number of entries; any value >= 2.
- DATA_W, 8: entry width in bits.
- AF_LEVEL, DEPTH-2: almost_full asserts when level >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when level <= AE_LEVEL; legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- mode  in  1  requested ordering: 0 = FIFO, 1 = LIFO. Applied only per the mode rules under Behaviour.
- write  in  1  push/enqueue request.
- read  in  1  pop/dequeue request.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  current head (FIFO) or top (LIFO) entry; combinational from state.
- val  out  1  buffer non-empty (level != 0).
- full  out  1  level == DEPTH.
- level  out  $clog2(DEPTH+1)  current occupancy.
- almost_full  out  1  level >= AF_LEVEL.
- almost_empty  out  1  level <= AE_LEVEL.
- cur_mode  out  1  mode currently in effect.
- overflow  out  1  registered one-cycle pulse: a write was dropped.
- underflow  out  1  registered one-cycle pulse: a read was made while empty.

Behaviour:
Reset (asynchronous, immediate on assertion):
- level=0, wr_ptr=0, rd_ptr=0, cur_mode=0, overflow=0, underflow=0.
- Therefore val=0, full=0, almost_empty=1, almost_full=0, data_out=0.
- Memory contents are not reset.
- Reset asserted mid-operation discards all contents; no pulse is generated.

Mode selection:
- cur_mode <= mode on any edge where level==0 and write==0.
- Otherwise cur_mode holds, so a mode change while data is stored is ignored until the buffer drains.

Pointers:
- wr_ptr and rd_ptr range over 0..DEPTH-1.
- Increment wraps DEPTH-1 -> 0; decrement wraps 0 -> DEPTH-1.

Effective operations:
- rd_ok = read & val.
- wr_ok = write & (!full | rd_ok).

FIFO (cur_mode=0):
- wr_ok: mem[wr_ptr] <= data_in; wr_ptr++.
- rd_ok: rd_ptr++.
- level changes by (+1 if wr_ok only) or (-1 if rd_ok only); unchanged if both or neither.
- Simultaneous read+write when full: both take effect; level stays DEPTH.
- Simultaneous read+write when empty: write only.
- data_out = mem[rd_ptr] when val, else 0.

LIFO (cur_mode=1):
- Top entry is mem[wr_ptr-1], with wrap.
- wr_ok only: mem[wr_ptr] <= data_in; wr_ptr++; level+1.
- rd_ok only: wr_ptr--; level-1.
- Both (val=1): replace top, mem[wr_ptr-1] <= data_in; wr_ptr and level unchanged. This applies at full too.
- Both with val=0: push only.
- rd_ptr is unused in LIFO mode.
- data_out = mem[wr_ptr-1] when val, else 0.

Errors:
- overflow <= write & full & !read.
- underflow <= read & !val.
- Each is a one-cycle registered pulse in the cycle after the offending request. The dropped request changes no state.

Latency:
- Written data is visible on data_out the cycle after the write edge, if it is the head (FIFO) or top (LIFO).
- Status outputs derive combinationally from the registered level.

Test Plan:
- FIFO order: reset, mode=0, write 0x11,0x22,0x33 on consecutive cycles -> level=3; reads return 0x11,0x22,0x33 in order; then val=0, data_out=0, almost_empty=1.
- LIFO order and mode latch: empty, mode=1, push 0xA1,0xA2,0xA3 -> cur_mode=1, data_out=0xA3; drive mode=0 while level=3 -> cur_mode stays 1; pops return 0xA3,0xA2,0xA1; next idle edge -> cur_mode=0.
- FIFO wrap with DEPTH=5: 4 writes, 3 reads, 4 writes -> pointers wrap past 4; full=1, almost_full=1 (AF_LEVEL=3); output order preserved across the wrap.
- Full boundary, DEPTH=8: fill to level=8, write without read -> overflow pulse for one cycle and contents unchanged. FIFO read+write at full -> level=8, head advances. LIFO read+write at full -> top replaced by data_in, level=8.
- Empty boundary: read at level=0 -> underflow pulse, level=0. Read+write at empty in either mode -> level=1, data_out=data_in, and underflow pulses.
- Async reset mid-stream: assert reset between clock edges at level=5 -> level=0, val=0, data_out=0 immediately; after release, first write is read back correctly.

Source files
------------

// File: rtl/lifo_fifo_buffer_if.sv
// lifo_fifo_buffer_if: producer/consumer handshake and status bundle for lifo_fifo_buffer.
interface lifo_fifo_buffer_if #(
  parameter int DATA_W = 8,
  parameter int LW     = 4
);
  logic              mode;
  logic              write;
  logic              read;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              val;
  logic              full;
  logic [LW-1:0]     level;
  logic              almost_full;
  logic              almost_empty;
  logic              cur_mode;
  logic              overflow;
  logic              underflow;
  modport master (
    output mode, write, read, data_in,
    input  data_out, val, full, level, almost_full, almost_empty, cur_mode, overflow, underflow
  );
  modport slave (
    input  mode, write, read, data_in,
    output data_out, val, full, level, almost_full, almost_empty, cur_mode, overflow, underflow
  );
endinterface

// File: rtl/lifo_fifo_buffer.sv
// lifo_fifo_buffer: DEPTH-entry buffer with run-time FIFO/LIFO ordering, thresholds and error pulses.
module lifo_fifo_buffer #(
  parameter int DEPTH    = 8,
  parameter int DATA_W   = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input logic               clk,
  input logic               reset,
  lifo_fifo_buffer_if.slave b
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] AF = LW'(AF_LEVEL);
  localparam logic [LW-1:0] AE = LW'(AE_LEVEL);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, top, wr_inc, rd_inc, mem_addr;
  logic [LW-1:0] level_q, level_d;
  logic cur_mode_q, cur_mode_d, overflow_q, overflow_d, underflow_q, underflow_d;
  logic val, full, rd_ok, wr_ok, mem_we;
  assign val    = level_q != '0;
  assign full   = level_q == FULL_LVL;
  assign top    = wr_ptr_q == '0 ? LAST : wr_ptr_q - 1'b1;
  assign wr_inc = wr_ptr_q == LAST ? '0 : wr_ptr_q + 1'b1;
  assign rd_inc = rd_ptr_q == LAST ? '0 : rd_ptr_q + 1'b1;
  assign rd_ok  = b.read & val;
  assign wr_ok  = b.write & (!full | rd_ok);
  always_comb begin
    mem_we      = wr_ok;
    mem_addr    = (cur_mode_q && rd_ok) ? top : wr_ptr_q;
    wr_ptr_d    = !wr_ok ? ((cur_mode_q && rd_ok) ? top : wr_ptr_q)
                         : ((cur_mode_q && rd_ok) ? wr_ptr_q : wr_inc);
    // rd_ptr shadows wr_ptr in LIFO so FIFO ordering is valid after a mode switch
    rd_ptr_d    = cur_mode_q ? wr_ptr_d : (rd_ok ? rd_inc : rd_ptr_q);
    level_d     = level_q + LW'(wr_ok & !rd_ok) - LW'(rd_ok & !wr_ok);
    cur_mode_d  = (!val && !b.write) ? b.mode : cur_mode_q;
    overflow_d  = b.write & full & !b.read;
    underflow_d = b.read & !val;
  end
  always_ff @(posedge clk) if (mem_we) mem_q[mem_addr] <= b.data_in;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      cur_mode_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      cur_mode_q  <= cur_mode_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  assign b.data_out     = val ? mem_q[cur_mode_q ? top : rd_ptr_q] : '0;
  assign b.val          = val;
  assign b.full         = full;
  assign b.level        = level_q;
  assign b.almost_full  = level_q >= AF;
  assign b.almost_empty = level_q <= AE;
  assign b.cur_mode     = cur_mode_q;
  assign b.overflow     = overflow_q;
  assign b.underflow    = underflow_q;
endmodule
